tick_rate_ctrl: RTL and testbench
=================================

# tick_rate_ctrl

Programmable tick scheduler built on the power-of-2 clock divider. It runs an internal divide counter and emits a single-cycle `Tick_out` enable every 2^E clock cycles, where E is a run-time exponent. Downstream logic uses the enable in place of a divided clock. Rate changes use a request/acknowledge handshake and while running take effect only at a period boundary, so no period is truncated. Run, stop and single-step controls sequence the tick stream.

## Interface
- `SIZE`, 36, maximum exponent and counter width in bits.
- `EXP_W`, 6, width of the exponent fields; must satisfy 2^EXP_W > SIZE.
- `DEFAULT_EXP`, 25, exponent loaded at reset; must be ≤ SIZE.

Ports:
- `CLK_in`  in  1  sole clock, rising edge.
- `RST_n_in`  in  1  asynchronous, active-low reset.
- `Run_in`  in  1  level: 1 = generate ticks, 0 = stopped.
- `Step_in`  in  1  pulse: emit one tick while stopped.
- `Cfg_Req_in`  in  1  single-cycle rate-change request.
- `Cfg_Exp_in`  in  EXP_W  requested exponent, sampled with `Cfg_Req_in`.
- `Cfg_Ack_out`  out  1  one-cycle pulse: new exponent applied.
- `Cfg_Err_out`  out  1  one-cycle pulse: request rejected.
- `Busy_out`  out  1  accepted change is pending.
- `Tick_out`  out  1  registered one-cycle enable.
- `Exp_out`  out  EXP_W  exponent in effect.
- `Count_out`  out  SIZE  internal counter C.

## Operation
- FSM states:
  - STOP: C held at 0.
  - RUN.
  - PEND: running with a change latched in the pending register P.
- At every edge, if `Run_in`=0 the FSM goes to STOP, C is set to 0 and `Tick_out` is set to 0.
  - Exception: in PEND, P is applied (`Exp_out`←P, `Cfg_Ack_out`=1) before entering STOP.
- Run rule, at each edge with `Run_in`=1 (from any state):
  - If C == 2^E−1: C←0 and `Tick_out`←1.
  - Otherwise: C←C+1 and `Tick_out`←0.
  - With E=0, `Tick_out` stays continuously high.
- Request handling (`Cfg_Req_in`=1 at an edge):
  - If `Cfg_Exp_in` > SIZE, or the FSM is in PEND: `Cfg_Err_out`=1. No state change, request dropped.
  - Else if `Run_in`=0: `Exp_out`←`Cfg_Exp_in` and `Cfg_Ack_out`=1. C stays 0.
  - Else (`Run_in`=1): P←`Cfg_Exp_in`, go to PEND, `Busy_out`=1. The run rule still applies to this edge using the old E.
- In PEND at the terminal edge (C == 2^E−1 with the old E):
  - `Tick_out`=1 (completes the old period).
  - `Exp_out`←P, C←0, `Cfg_Ack_out`=1, `Busy_out`=0, go to RUN.
- `Step_in`=1 in STOP with `Run_in`=0: `Tick_out`=1 for one cycle and C stays 0. `Step_in` is ignored when `Run_in`=1.
- Reset values: state STOP, C=0, `Exp_out`=DEFAULT_EXP, P=0. `Tick_out`, `Cfg_Ack_out`, `Cfg_Err_out` and `Busy_out` are all 0.
- Reset mid-operation discards any pending change; no Ack is issued.

## Timing
- All outputs are registered and update on the edge that samples their cause. Ack, Err and Step-tick are visible one cycle after the request or step.
- From STOP, with `Run_in` held high from edge k, the first `Tick_out` is high after edge k+2^E−1; ticks then repeat every 2^E cycles.
- Latency of a change while running: it is applied on the first terminal edge after acceptance, at most 2^E_old cycles.
  - If the request lands on the terminal edge itself, the next full old period completes first.
- Simultaneous Req and `Run_in` falling edge: the `Run_in`=0 path applies. The request is applied immediately, Ack is issued, and the FSM is in STOP.
- The asynchronous reset assertion clears outputs without waiting for a clock edge. Deassertion is synchronized externally.

## Test plan
- Reset: assert `RST_n_in` low mid-run with no clock edge → outputs clear immediately; `Exp_out`=25, C=0, all pulses 0.
- Stopped config then run: Req with Exp=2 while `Run_in`=0 → Ack one cycle later, `Exp_out`=2. Raise `Run_in` → first tick after the 4th edge, then every 4 cycles. Repeat with Exp=0 → `Tick_out` held high.
- Change while running: E=3 running, Req with Exp=1 when C=2 → `Busy_out` high for 5 cycles. The tick at C=7 coincides with Ack; subsequent ticks every 2 cycles.
- Rejections: Req with Exp=37 (SIZE=36) → Err pulse, `Exp_out` unchanged. A second valid Req while in PEND → Err pulse, first change still applied at the boundary.
- Stop/step: drop `Run_in` while in PEND → Ack next cycle, new E in effect, C=0. Step in STOP → exactly one tick. Step with `Run_in`=1 → tick cadence unchanged.
- Boundary: with SIZE=4 and DEFAULT_EXP=4 → tick period 16 cycles, C wraps from 15 to 0. Req Exp=4 → Ack; Req Exp=5 → Err.

Source files
------------

// File: rtl/tick_rate_ctrl.sv
// Programmable tick scheduler: emits a one-cycle Tick_out enable every 2^E clocks.
// A new E is taken through a req/ack handshake and, while running, only at a period boundary.
module tick_rate_ctrl #(
  parameter int SIZE        = 36,
  parameter int EXP_W       = 6,
  parameter int DEFAULT_EXP = 25
) (
  input  logic             CLK_in,
  input  logic             RST_n_in,
  input  logic             Run_in,
  input  logic             Step_in,
  input  logic             Cfg_Req_in,
  input  logic [EXP_W-1:0] Cfg_Exp_in,
  output logic             Cfg_Ack_out,
  output logic             Cfg_Err_out,
  output logic             Busy_out,
  output logic             Tick_out,
  output logic [EXP_W-1:0] Exp_out,
  output logic [SIZE-1:0]  Count_out
);

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } stateT;

  localparam logic [EXP_W-1:0] MaxExp   = EXP_W'(SIZE);
  localparam logic [EXP_W-1:0] ResetExp = EXP_W'(DEFAULT_EXP);

  stateT            state_q, state_d;
  logic [SIZE-1:0]  count_q, count_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [EXP_W-1:0] pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic [SIZE-1:0]  termCount;
  logic             terminal;
  logic             reqBad;
  logic             reqOk;

  // Terminal count 2^E-1 as a mask; E == SIZE yields all ones, E == 0 yields zero.
  assign termCount = ~({SIZE{1'b1}} << exp_q);
  assign terminal  = (count_q == termCount);
  assign reqBad    = Cfg_Req_in && ((Cfg_Exp_in > MaxExp) || (state_q == PEND));
  assign reqOk     = Cfg_Req_in && !reqBad;

  always_ff @(posedge CLK_in or negedge RST_n_in) begin
    if (!RST_n_in) begin
      state_q <= STOP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!Run_in) begin
      state_d = STOP;
    end else begin
      case (state_q)
        STOP, RUN: state_d = reqOk ? PEND : RUN;
        PEND:      state_d = terminal ? RUN : PEND;
        default:   state_d = STOP;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    exp_d   = exp_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    ack_d   = 1'b0;
    err_d   = reqBad;
    if (!Run_in) begin
      count_d = '0;
      tick_d  = Step_in && (state_q == STOP);
      // A change still pending when the run stops is applied rather than lost.
      if (state_q == PEND) begin
        exp_d = pend_q;
        ack_d = 1'b1;
      end else if (reqOk) begin
        exp_d = Cfg_Exp_in;
        ack_d = 1'b1;
      end
    end else begin
      if (terminal) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + SIZE'(1);
      end
      if (reqOk) begin
        pend_d = Cfg_Exp_in;
      end
      if ((state_q == PEND) && terminal) begin
        exp_d = pend_q;
        ack_d = 1'b1;
      end
    end
    busy_d = (state_d == PEND);
  end

  always_ff @(posedge CLK_in or negedge RST_n_in) begin
    if (!RST_n_in) begin
      count_q <= '0;
      exp_q   <= ResetExp;
      pend_q  <= '0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      exp_q   <= exp_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign Tick_out    = tick_q;
  assign Cfg_Ack_out = ack_q;
  assign Cfg_Err_out = err_q;
  assign Busy_out    = busy_q;
  assign Exp_out     = exp_q;
  assign Count_out   = count_q;

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Scoreboard bench for tick_rate_ctrl: a default-size instance and a SIZE=4 instance
// for the wrap and exponent-limit boundaries.
module tb_tick_rate_ctrl;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  logic       run0 = 1'b0, step0 = 1'b0, req0 = 1'b0;
  logic [5:0] exp0In = '0;
  logic       ack0, err0, busy0, tick0;
  logic [5:0] expOut0;
  logic [35:0] cnt0;

  logic       run1 = 1'b0, step1 = 1'b0, req1 = 1'b0;
  logic [2:0] exp1In = '0;
  logic       ack1, err1, busy1, tick1;
  logic [2:0] expOut1;
  logic [3:0] cnt1;

  int cyc      = 0;
  int lastEdge = 0;
  int errors   = 0;
  int checks   = 0;

  typedef struct {
    int          edgeIdx;
    bit          which;
    string       name;
    logic [3:0]  flags;
    logic [5:0]  expv;
    logic [35:0] cnt;
  } expT;

  expT sbQ[$];

  tick_rate_ctrl #(.SIZE(36), .EXP_W(6), .DEFAULT_EXP(25)) u0 (
    .CLK_in(clk), .RST_n_in(rstN), .Run_in(run0), .Step_in(step0),
    .Cfg_Req_in(req0), .Cfg_Exp_in(exp0In), .Cfg_Ack_out(ack0),
    .Cfg_Err_out(err0), .Busy_out(busy0), .Tick_out(tick0),
    .Exp_out(expOut0), .Count_out(cnt0)
  );

  tick_rate_ctrl #(.SIZE(4), .EXP_W(3), .DEFAULT_EXP(4)) u1 (
    .CLK_in(clk), .RST_n_in(rstN), .Run_in(run1), .Step_in(step1),
    .Cfg_Req_in(req1), .Cfg_Exp_in(exp1In), .Cfg_Ack_out(ack1),
    .Cfg_Err_out(err1), .Busy_out(busy1), .Tick_out(tick1),
    .Exp_out(expOut1), .Count_out(cnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change on the falling edge; the next rising edge (lastEdge) samples them.
  task automatic applyStimulus(input bit which, input logic run, input logic step,
                               input logic req, input logic [5:0] e);
    @(negedge clk);
    run0 = 1'b0; step0 = 1'b0; req0 = 1'b0; exp0In = '0;
    run1 = 1'b0; step1 = 1'b0; req1 = 1'b0; exp1In = '0;
    if (which == 1'b0) begin
      run0 = run; step0 = step; req0 = req; exp0In = e;
    end else begin
      run1 = run; step1 = step; req1 = req; exp1In = e[2:0];
    end
    lastEdge = cyc + 1;
  endtask

  task automatic expectOut(input bit which, input string nm, input logic tick,
                           input logic ack, input logic err, input logic busy,
                           input logic [5:0] e, input logic [35:0] c);
    expT x;
    x.edgeIdx = lastEdge;
    x.which   = which;
    x.name    = nm;
    x.flags   = {tick, ack, err, busy};
    x.expv    = e;
    x.cnt     = c;
    sbQ.push_back(x);
  endtask

  task automatic stepCheck(input bit which, input string nm, input logic run,
                           input logic step, input logic req, input logic [5:0] e,
                           input logic tick, input logic ack, input logic err,
                           input logic busy, input logic [5:0] ex, input logic [35:0] c);
    applyStimulus(which, run, step, req, e);
    expectOut(which, nm, tick, ack, err, busy, ex, c);
  endtask

  task automatic checkOutput(input expT x);
    logic [3:0]  gotF;
    logic [5:0]  gotE;
    logic [35:0] gotC;
    if (x.which == 1'b0) begin
      gotF = {tick0, ack0, err0, busy0};
      gotE = expOut0;
      gotC = cnt0;
    end else begin
      gotF = {tick1, ack1, err1, busy1};
      gotE = {3'b000, expOut1};
      gotC = {32'd0, cnt1};
    end
    checks++;
    if ({gotF, gotE, gotC} !== {x.flags, x.expv, x.cnt}) begin
      errors++;
      $display("[TB] FAIL %s (dut %0d edge %0d): got tick/ack/err/busy=%b exp=%0d cnt=%0d, expected tick/ack/err/busy=%b exp=%0d cnt=%0d",
               x.name, x.which, x.edgeIdx, gotF, gotE, gotC, x.flags, x.expv, x.cnt);
    end
  endtask

  // Monitor: pops every expectation whose edge has been reached and compares it.
  always @(negedge clk) begin : monitor
    expT x;
    while (sbQ.size() > 0 && sbQ[0].edgeIdx <= cyc) begin
      x = sbQ.pop_front();
      if (x.edgeIdx < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: expectation for edge %0d reached monitor late at edge %0d",
                 x.name, x.edgeIdx, cyc);
      end else begin
        checkOutput(x);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    lastEdge = 1;
    expectOut(1'b0, "reset0", 0, 0, 0, 0, 6'd25, 36'd0);
    expectOut(1'b1, "reset1", 0, 0, 0, 0, 6'd4, 36'd0);
    applyStimulus(1'b0, 0, 0, 0, 6'd0);
    rstN = 1'b1;
    expectOut(1'b0, "idleAfterReset", 0, 0, 0, 0, 6'd25, 36'd0);

    // Stopped configuration, then run with period 4 (step while running is ignored).
    stepCheck(1'b0, "cfgStopExp2", 0, 0, 1, 6'd2, 0, 1, 0, 0, 6'd2, 36'd0);
    for (int i = 1; i <= 12; i++)
      stepCheck(1'b0, "runE2", 1, (i == 6), 0, 6'd0, (i % 4 == 0), 0, 0, 0, 6'd2, 36'(i % 4));
    stepCheck(1'b0, "stopE2", 0, 0, 0, 6'd0, 0, 0, 0, 0, 6'd2, 36'd0);
    stepCheck(1'b0, "stepInStop", 0, 1, 0, 6'd0, 1, 0, 0, 0, 6'd2, 36'd0);
    stepCheck(1'b0, "afterStep", 0, 0, 0, 6'd0, 0, 0, 0, 0, 6'd2, 36'd0);

    // E = 0: tick held high.
    stepCheck(1'b0, "cfgStopExp0", 0, 0, 1, 6'd0, 0, 1, 0, 0, 6'd0, 36'd0);
    for (int i = 0; i < 5; i++)
      stepCheck(1'b0, "runE0", 1, 0, 0, 6'd0, 1, 0, 0, 0, 6'd0, 36'd0);
    stepCheck(1'b0, "stopE0", 0, 0, 0, 6'd0, 0, 0, 0, 0, 6'd0, 36'd0);

    // Change while running: E=3, request E=1 at C=2, second request rejected in PEND.
    stepCheck(1'b0, "cfgStopExp3", 0, 0, 1, 6'd3, 0, 1, 0, 0, 6'd3, 36'd0);
    stepCheck(1'b0, "runE3", 1, 0, 0, 6'd0, 0, 0, 0, 0, 6'd3, 36'd1);
    stepCheck(1'b0, "runE3", 1, 0, 0, 6'd0, 0, 0, 0, 0, 6'd3, 36'd2);
    stepCheck(1'b0, "reqWhileRun", 1, 0, 1, 6'd1, 0, 0, 0, 1, 6'd3, 36'd3);
    stepCheck(1'b0, "pend", 1, 0, 0, 6'd0, 0, 0, 0, 1, 6'd3, 36'd4);
    stepCheck(1'b0, "reqInPendErr", 1, 0, 1, 6'd4, 0, 0, 1, 1, 6'd3, 36'd5);
    stepCheck(1'b0, "pend", 1, 0, 0, 6'd0, 0, 0, 0, 1, 6'd3, 36'd6);
    stepCheck(1'b0, "pend", 1, 0, 0, 6'd0, 0, 0, 0, 1, 6'd3, 36'd7);
    stepCheck(1'b0, "boundaryAck", 1, 0, 0, 6'd0, 1, 1, 0, 0, 6'd1, 36'd0);
    stepCheck(1'b0, "runE1", 1, 0, 0, 6'd0, 0, 0, 0, 0, 6'd1, 36'd1);
    stepCheck(1'b0, "runE1", 1, 0, 0, 6'd0, 1, 0, 0, 0, 6'd1, 36'd0);
    stepCheck(1'b0, "runE1", 1, 0, 0, 6'd0, 0, 0, 0, 0, 6'd1, 36'd1);

    // Out-of-range request, then a request landing on the terminal edge.
    stepCheck(1'b0, "reqTooBig", 1, 0, 1, 6'd37, 1, 0, 1, 0, 6'd1, 36'd0);
    stepCheck(1'b0, "runE1", 1, 0, 0, 6'd0, 0, 0, 0, 0, 6'd1, 36'd1);
    stepCheck(1'b0, "reqOnTerminal", 1, 0, 1, 6'd2, 1, 0, 0, 1, 6'd1, 36'd0);
    stepCheck(1'b0, "pendFullPeriod", 1, 0, 0, 6'd0, 0, 0, 0, 1, 6'd1, 36'd1);
    stepCheck(1'b0, "ackAfterFullPeriod", 1, 0, 0, 6'd0, 1, 1, 0, 0, 6'd2, 36'd0);

    // Dropping Run in PEND applies the pending exponent; Req with Run falling acks at once.
    stepCheck(1'b0, "reqE3", 1, 0, 1, 6'd3, 0, 0, 0, 1, 6'd2, 36'd1);
    stepCheck(1'b0, "dropRunInPend", 0, 0, 0, 6'd0, 0, 1, 0, 0, 6'd3, 36'd0);
    stepCheck(1'b0, "runE3b", 1, 0, 0, 6'd0, 0, 0, 0, 0, 6'd3, 36'd1);
    stepCheck(1'b0, "reqWithRunFall", 0, 0, 1, 6'd2, 0, 1, 0, 0, 6'd2, 36'd0);

    // Asynchronous reset mid-run with a change pending: cleared without a clock edge, no Ack.
    stepCheck(1'b0, "e2Run", 1, 0, 0, 6'd0, 0, 0, 0, 0, 6'd2, 36'd1);
    stepCheck(1'b0, "pendBeforeReset", 1, 0, 1, 6'd4, 0, 0, 0, 1, 6'd2, 36'd2);
    stepCheck(1'b0, "pendBeforeReset", 1, 0, 0, 6'd0, 0, 0, 0, 1, 6'd2, 36'd3);
    applyStimulus(1'b0, 1, 0, 0, 6'd0);
    expectOut(1'b0, "asyncResetClears", 0, 0, 0, 0, 6'd25, 36'd0);
    @(posedge clk);
    #2;
    rstN = 1'b0;
    stepCheck(1'b0, "holdReset", 0, 0, 0, 6'd0, 0, 0, 0, 0, 6'd25, 36'd0);
    stepCheck(1'b0, "holdReset", 0, 0, 0, 6'd0, 0, 0, 0, 0, 6'd25, 36'd0);
    applyStimulus(1'b0, 0, 0, 0, 6'd0);
    rstN = 1'b1;
    expectOut(1'b0, "noAckAfterReset", 0, 0, 0, 0, 6'd25, 36'd0);

    // Small instance: period 16 with wrap 15 -> 0, exponent limit 4.
    for (int i = 1; i <= 17; i++)
      stepCheck(1'b1, "smallRun", 1, 0, 0, 6'd0, (i % 16 == 0), 0, 0, 0, 6'd4, 36'(i % 16));
    stepCheck(1'b1, "smallStop", 0, 0, 0, 6'd0, 0, 0, 0, 0, 6'd4, 36'd0);
    stepCheck(1'b1, "smallReqMax", 0, 0, 1, 6'd4, 0, 1, 0, 0, 6'd4, 36'd0);
    stepCheck(1'b1, "smallReqOver", 0, 0, 1, 6'd5, 0, 0, 1, 0, 6'd4, 36'd0);
    stepCheck(1'b1, "smallReqE1", 0, 0, 1, 6'd1, 0, 1, 0, 0, 6'd1, 36'd0);
    stepCheck(1'b1, "smallIdle", 0, 0, 0, 6'd0, 0, 0, 0, 0, 6'd1, 36'd0);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboardDrain: %0d expectations left, required 0", sbQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
